hazard_stall_controller: RTL and testbench

Pipeline control block that sits between the ID/EX, IF/ID and EX/MEM pipeline registers. It decides, every cycle, whether each register loads, holds, or loads a bubble. It reads the EX-side outputs of the ID/EX register (destination register, load flag, branch resolution) and the ID-side source operands. From these it drives the PC write enable, the IF/ID write and flush, the ID/EX write and bubble, and the EX/MEM hold. A small FSM handles load-use stalls and multi-cycle data-memory waits, including a watchdog on the memory handshake.

---
 rtl/hazard_stall_controller.sv | 137 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: decides per cycle whether the PC, IF/ID, ID/EX and
// EX/MEM registers load, hold or take a bubble. Handles load-use stalls, taken
// branch squashes and data-memory waits with a sticky watchdog flag.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating event counters
// (loadStallCnt, flushCnt, memWaitCnt).
module hazard_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             usesRs1_ID,
  input  logic             usesRs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memRead_EX,
  input  logic             branchTaken_EX,
  input  logic             memReq_MEM,
  input  logic             memReady_MEM,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexWrite,
  output logic             idexBubble,
  output logic             exmemHold,
  output logic             memTimeout,
  output logic [1:0]       stallState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] loadStallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] memWaitCnt
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

  state_e      state;
  state_e      state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic        load_use;
  logic        mem_wait;
  logic        rule_mem;
  logic        rule_br;
  logic        rule_lu;

  // Hazard detection and rule priority; MEM_WAIT exit cycle behaves as RUN
  always_comb begin
    load_use = memRead_EX && (rd_EX != '0) &&
               ((usesRs1_ID && (rs1_ID == rd_EX)) ||
                (usesRs2_ID && (rs2_ID == rd_EX)));
    mem_wait = memReq_MEM && !memReady_MEM;
    rule_mem = mem_wait;
    rule_br  = !mem_wait && branchTaken_EX;
    rule_lu  = !mem_wait && !branchTaken_EX && load_use && (state != LOAD_STALL);

    if (rule_mem)     state_nxt = MEM_WAIT;
    else if (rule_lu) state_nxt = LOAD_STALL;
    else              state_nxt = RUN;

    // Wait counter counts the entering cycle as 1, so it reaches MEM_TIMEOUT
    // on the edge closing the MEM_TIMEOUT-th consecutive wait cycle.
    if (state != MEM_WAIT)           wait_nxt = 16'd1;
    else if (wait_cnt < TIMEOUT_LIM) wait_nxt = wait_cnt + 16'd1;
    else                             wait_nxt = wait_cnt;
  end

  // Mealy pipeline-control outputs, forced to flush/bubble while in reset
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexWrite  = 1'b1;
    idexBubble = 1'b0;
    exmemHold  = 1'b0;
    if (!rstN) begin
      pcWrite    = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (rule_mem) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemHold  = 1'b1;
    end else if (rule_br) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (rule_lu) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end
  end

  // FSM state, watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= RUN;
      wait_cnt   <= '0;
      memTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_wait) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == TIMEOUT_LIM) memTimeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign stallState = state;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters for load stalls, branch flushes and memory waits
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      loadStallCnt <= '0;
      flushCnt     <= '0;
      memWaitCnt   <= '0;
    end else begin
      if (rule_lu && (loadStallCnt != '1)) loadStallCnt <= loadStallCnt + CNT_W'(1);
      if (rule_br && (flushCnt != '1))     flushCnt     <= flushCnt + CNT_W'(1);
      if (rule_mem && (memWaitCnt != '1))  memWaitCnt   <= memWaitCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed scenarios followed by
// randomized stimulus, all compared against a behavioural reference model.
module tb_hazard_stall_controller;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       usesRs1_ID, usesRs2_ID, memRead_EX, branchTaken_EX;
  logic       memReq_MEM, memReady_MEM;
  logic       pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemHold;
  logic       memTimeout;
  logic [1:0] stallState;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] loadStallCnt, flushCnt, memWaitCnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_stalled;   // a load-use bubble was inserted last cycle
  bit          m_waiting;   // last cycle was a memory wait
  bit          m_tmo;
  int unsigned m_run;       // consecutive wait cycles so far
  int unsigned m_cls, m_cfl, m_cmw;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rstN(rstN),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .usesRs1_ID(usesRs1_ID), .usesRs2_ID(usesRs2_ID),
    .rd_EX(rd_EX), .memRead_EX(memRead_EX), .branchTaken_EX(branchTaken_EX),
    .memReq_MEM(memReq_MEM), .memReady_MEM(memReady_MEM),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .idexWrite(idexWrite), .idexBubble(idexBubble), .exmemHold(exmemHold),
    .memTimeout(memTimeout), .stallState(stallState)
`ifdef HAZARD_PERF_CNT_EN
    , .loadStallCnt(loadStallCnt), .flushCnt(flushCnt), .memWaitCnt(memWaitCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit f_load_use();
    return memRead_EX && (rd_EX != 5'd0) &&
           ((usesRs1_ID && rs1_ID == rd_EX) || (usesRs2_ID && rs2_ID == rd_EX));
  endfunction

  // {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemHold}
  function automatic logic [5:0] f_exp_ctrl();
    if (!rstN)                             return 6'b011110;
    if (memReq_MEM && !memReady_MEM)       return 6'b000001;
    if (branchTaken_EX)                    return 6'b111110;
    if (f_load_use() && !m_stalled)        return 6'b000110;
    return 6'b110100;
  endfunction

  function automatic logic [1:0] f_exp_state();
    if (m_waiting) return 2'd2;
    if (m_stalled) return 2'd1;
    return 2'd0;
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v < ((32'd1 << CW) - 1)) ? v + 1 : v;
  endfunction

  task automatic check_all();
    check("ctrl", {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemHold}, f_exp_ctrl());
    check("state", stallState, f_exp_state());
    check("timeout", memTimeout, m_tmo);
`ifdef HAZARD_PERF_CNT_EN
    check("cnt_ls", loadStallCnt, m_cls);
    check("cnt_fl", flushCnt, m_cfl);
    check("cnt_mw", memWaitCnt, m_cmw);
`endif
  endtask

  task automatic model_reset();
    m_stalled = 0; m_waiting = 0; m_tmo = 0; m_run = 0;
    m_cls = 0; m_cfl = 0; m_cmw = 0;
  endtask

  // Apply the priority rules to the current inputs to advance the model one edge
  task automatic model_edge();
    bit wait_now, lu;
    if (!rstN) return;
    wait_now = memReq_MEM && !memReady_MEM;
    lu = f_load_use();
    if (wait_now) begin
      m_run = m_waiting ? m_run + 1 : 1;
      if (m_run >= TMO) m_tmo = 1;
      m_waiting = 1; m_stalled = 0; m_cmw = sat(m_cmw);
    end else if (branchTaken_EX) begin
      m_waiting = 0; m_stalled = 0; m_cfl = sat(m_cfl);
    end else if (lu && !m_stalled) begin
      m_waiting = 0; m_stalled = 1; m_cls = sat(m_cls);
    end else begin
      m_waiting = 0; m_stalled = 0;
    end
  endtask

  // Called at a falling edge with inputs already applied
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic idle_inputs();
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
    usesRs1_ID = 0; usesRs2_ID = 0; memRead_EX = 0; branchTaken_EX = 0;
    memReq_MEM = 0; memReady_MEM = 1;
  endtask

  initial begin
    int hold_cycles;
    idle_inputs();
    rstN = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rstN = 1'b1;

    // load-use: lw x5 in EX, ID reads x5 via rs1
    memRead_EX = 1; rd_EX = 5'd5; rs1_ID = 5'd5; usesRs1_ID = 1;
    #1;
    check("lu_pcw", pcWrite, 1'b0);
    check("lu_ifw", ifidWrite, 1'b0);
    check("lu_bub", idexBubble, 1'b1);
    step();
    #1;
    check("lu_state", stallState, 2'd1);
    check("lu_pcw2", pcWrite, 1'b1);
    step();

    // x0 destination and unused operand never stall
    idle_inputs();
    memRead_EX = 1; rd_EX = 5'd0; rs1_ID = 5'd0; usesRs1_ID = 1;
    #1 check("x0_pcw", pcWrite, 1'b1);
    step();
    usesRs1_ID = 0; rd_EX = 5'd7; rs2_ID = 5'd7; usesRs2_ID = 0;
    #1 check("unused_pcw", pcWrite, 1'b1);
    step();

    // branch wins over simultaneous load-use
    idle_inputs();
    memRead_EX = 1; rd_EX = 5'd5; rs1_ID = 5'd5; usesRs1_ID = 1; branchTaken_EX = 1;
    #1;
    check("br_flush", ifidFlush, 1'b1);
    check("br_bub", idexBubble, 1'b1);
    check("br_pcw", pcWrite, 1'b1);
    step();
    check("br_state", stallState, 2'd0);

    // memory wait of 3 cycles then ready
    idle_inputs();
    do_reset();
    hold_cycles = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      memReq_MEM = 1; memReady_MEM = (k == 3);
      #1 hold_cycles += int'(exmemHold);
      step();
    end
    check("mw_hold_cycles", hold_cycles, 3);
    idle_inputs();
    #1 check("mw_advance", pcWrite, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
    check("mw_cnt", memWaitCnt, 3);
`endif
    step();

    // watchdog: ready held low past the limit
    memReq_MEM = 1; memReady_MEM = 0;
    for (int unsigned k = 0; k < TMO; k++) begin
      #1 check("wd_low", memTimeout, 1'b0);
      step();
    end
    check("wd_rise", memTimeout, 1'b1);
    check("wd_frozen", pcWrite, 1'b0);
    step();
    memReady_MEM = 1;
    step();
    check("wd_sticky", memTimeout, 1'b1);

    // reset mid-wait with the timeout flag set
    memReady_MEM = 0;
    step();
    step();
    check("pre_rst_state", stallState, 2'd2);
    rstN = 1'b0;
    model_reset();
    #1;
    check("rst_tmo", memTimeout, 1'b0);
    check("rst_state", stallState, 2'd0);
    check("rst_ctrl", {pcWrite, ifidWrite, ifidFlush, idexWrite, idexBubble, exmemHold}, 6'b011110);
    @(negedge clk);
    rstN = 1'b1;

    // randomized traffic with two memory-readiness regimes and sporadic resets
    for (int unsigned i = 0; i < 3000; i++) begin
      rs1_ID         = 5'($urandom_range(0, 3));
      rs2_ID         = 5'($urandom_range(0, 3));
      rd_EX          = 5'($urandom_range(0, 3));
      usesRs1_ID     = 1'($urandom_range(0, 1));
      usesRs2_ID     = 1'($urandom_range(0, 1));
      memRead_EX     = 1'($urandom_range(0, 1));
      branchTaken_EX = ($urandom_range(0, 99) < 15);
      memReq_MEM     = ($urandom_range(0, 99) < 30);
      memReady_MEM   = (i < 1500) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
